// File: rtl/lock_filt_pkg.sv
// Shared types and helpers for the lock-in filter stages.
// Gear states, port widths and a generic signed clip.
package lock_filt_pkg;

   localparam int unsigned TAU_W = 6;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned EFF_W = 4;

   typedef enum logic [1:0] {
      StFast   = 2'd0,
      StStep   = 2'd1,
      StTrack  = 2'd2,
      StBypass = 2'd3
   } gear_state_t;

   // Clip a signed value into the range of a signed 'width'-bit word.
   function automatic logic signed [63:0] sat_r(input logic signed [63:0] value,
                                                input int unsigned width);
      logic signed [63:0] v_max;
      logic signed [63:0] v_min;
      logic signed [63:0] v_res;
      v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
      v_min = -(64'sd1 <<< (width - 1));
      v_res = value;
      if (value > v_max) begin
         v_res = v_max;
      end else if (value < v_min) begin
         v_res = v_min;
      end
      return v_res;
   endfunction

endpackage

// File: rtl/hp_gear_ctrl.sv
// Gear-shift controller: ramps eff_tau from 0 up to the target tau, one step per dwell.
// Restarts on pulse or tau change; tau[5:4] != 0 selects bypass.
module hp_gear_ctrl
   import lock_filt_pkg::*;
#(
   parameter int unsigned GEAR_SH = 15
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [TAU_W-1:0]   i_tau,
   input  logic               i_restart,
   output logic [EFF_W-1:0]   o_eff_tau,
   output gear_state_t        o_state,
   output logic               o_settling
);

   gear_state_t        r_state;
   gear_state_t        w_state;
   logic [EFF_W-1:0]   r_eff_tau;
   logic [EFF_W-1:0]   w_eff_tau;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt;
   logic [CNT_W-1:0]   w_dwell_last;
   logic [TAU_W-1:0]   r_tau_q;
   logic               r_settling;
   logic [EFF_W-1:0]   w_target;
   logic               w_bypass;

   assign w_target     = i_tau[EFF_W-1:0];
   assign w_bypass     = |i_tau[TAU_W-1:EFF_W];
   // In FAST eff_tau is 0, so the same formula gives the gear-0 dwell.
   assign w_dwell_last = (CNT_W'(1) << (32'(r_eff_tau) + GEAR_SH)) - CNT_W'(1);

   always_comb begin
      w_state   = r_state;
      w_eff_tau = r_eff_tau;
      w_cnt     = r_cnt;
      if (w_bypass) begin
         w_state   = StBypass;
         w_eff_tau = '0;
         w_cnt     = '0;
      end else if (i_restart || (i_tau != r_tau_q) || (r_state == StBypass)) begin
         w_state   = StFast;
         w_eff_tau = '0;
         w_cnt     = '0;
      end else begin
         case (r_state)
            StFast: begin
               if (r_cnt == w_dwell_last) begin
                  w_cnt = '0;
                  if (w_target == '0) begin
                     w_state   = StTrack;
                     w_eff_tau = '0;
                  end else begin
                     w_eff_tau = EFF_W'(1);
                     w_state   = (w_target == EFF_W'(1)) ? StTrack : StStep;
                  end
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            StStep: begin
               if (r_cnt == w_dwell_last) begin
                  w_cnt     = '0;
                  w_eff_tau = r_eff_tau + EFF_W'(1);
                  if (w_eff_tau == w_target) begin
                     w_state = StTrack;
                  end
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            StTrack: begin
               w_eff_tau = w_target;
               w_cnt     = '0;
            end
            default: begin
               w_state   = StFast;
               w_eff_tau = '0;
               w_cnt     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= StFast;
         r_eff_tau  <= '0;
         r_cnt      <= '0;
         r_tau_q    <= i_tau;
         r_settling <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_eff_tau  <= w_eff_tau;
         r_cnt      <= w_cnt;
         r_tau_q    <= i_tau;
         r_settling <= (w_state == StFast) || (w_state == StStep);
      end
   end

   assign o_eff_tau  = r_eff_tau;
   assign o_state    = r_state;
   assign o_settling = r_settling;

endmodule

// File: rtl/hp_filter_gear.sv
// First-order IIR high-pass: out = in - LP(in), with gear-shifted LP time constant.
// LP accumulator keeps its baseline across restarts; only the gain is geared.
module hp_filter_gear
   import lock_filt_pkg::*;
#(
   parameter int unsigned R       = 14,
   parameter int unsigned S       = 58,
   parameter int unsigned FRAC    = 14,
   parameter int unsigned GEAR_SH = 15
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [TAU_W-1:0]   i_tau,
   input  logic               i_restart,
   input  logic [R-1:0]       i_in,
   output logic [R-1:0]       o_out,
   output logic               o_settling,
   output logic               o_sat
);

   localparam int unsigned LP_W = 31;

   logic [EFF_W-1:0]          w_eff_tau;
   gear_state_t               w_state;
   logic signed [S-1:0]       r_acc;
   logic [R-1:0]              r_out;
   logic                      r_sat;
   logic signed [S-FRAC-1:0]  w_acc_hi;
   logic signed [LP_W-1:0]    w_lp;
   logic signed [S:0]         w_acc_sum;
   logic signed [R:0]         w_diff;
   logic signed [63:0]        w_acc_clip;
   logic signed [63:0]        w_diff_clip;
   logic                      w_acc_sat;
   logic                      w_out_sat;

   hp_gear_ctrl #(
      .GEAR_SH (GEAR_SH)
   ) u_ctrl (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_tau      (i_tau),
      .i_restart  (i_restart),
      .o_eff_tau  (w_eff_tau),
      .o_state    (w_state),
      .o_settling (o_settling)
   );

   assign w_acc_hi  = r_acc[S-1:FRAC];
   assign w_lp      = LP_W'(w_acc_hi >>> w_eff_tau);
   assign w_acc_sum = (S+1)'(r_acc) + (S+1)'($signed(i_in)) - (S+1)'(w_lp);
   // Output uses only the low R bits of the LP term; it tracks the input range.
   assign w_diff    = (R+1)'($signed(i_in)) - (R+1)'($signed(w_lp[R-1:0]));

   assign w_acc_clip  = sat_r(64'(w_acc_sum), S);
   assign w_diff_clip = sat_r(64'(w_diff), R);
   assign w_acc_sat   = (w_acc_clip != 64'(w_acc_sum));
   assign w_out_sat   = (w_diff_clip != 64'(w_diff));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_out <= '0;
         r_sat <= 1'b0;
      end else if (w_state == StBypass) begin
         r_acc <= '0;
         r_out <= i_in;
         r_sat <= 1'b0;
      end else begin
         r_acc <= w_acc_clip[S-1:0];
         r_out <= w_diff_clip[R-1:0];
         r_sat <= w_acc_sat | w_out_sat;
      end
   end

   assign o_out = r_out;
   assign o_sat = r_sat;

endmodule
